core_reg_file_mp: RTL
=====================

Name: core_reg_file_mp

Overview:
Parametrised multi-port general-purpose register file for the core pipeline. It is the successor to the single-port register file and adds:
- configurable width, depth and read/write port counts;
- write-first bypass on every read port;
- an optional hardwired zero register;
- a counter-driven clear sequencer that zeroes the whole array after reset or on request.

Read data is registered: one cycle of latency, matching the existing decode/issue stage timing.

Parameters:
WIDTH, 32, bits per register
NUM_REGS, 16, number of registers (need not be a power of two, minimum 2)
RD_PORTS, 2, number of read ports
WR_PORTS, 2, number of write ports; higher port index has priority
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
IDX_W (derived localparam), $clog2(NUM_REGS), index width

Ports:
clk  in  1  core clock
rst_n  in  1  reset: asynchronous, active low
clear_req  in  1  pulse: start a full clear sequence (accepted only in READY)
rd_r  in  RD_PORTS*IDX_W  read indices; port i occupies bits [i*IDX_W +: IDX_W]
wr_r  in  WR_PORTS*IDX_W  write indices, same packing
wr_enable  in  WR_PORTS  per-port write enable
wr_value  in  WR_PORTS*WIDTH  write data, packed per port
rd_value  out  RD_PORTS*WIDTH  registered read data, packed per port
ready  out  1  1 = array initialised, reads/writes honoured

Behaviour:
- Reset (rst_n low, async): rd_value=0, ready=0, state=CLEAR, clear counter cnt=0. The array contents are not reset directly; they are zeroed by the sequencer.
- FSM states: CLEAR, READY.
- CLEAR:
  - each posedge writes file[cnt]<=0 and increments cnt.
  - when cnt==NUM_REGS-1 is written, the next state is READY, ready<=1 and cnt<=0.
  - ready therefore rises at the NUM_REGS-th posedge after rst_n deasserts.
  - All wr_enable are ignored; rd_value<=0 every cycle; clear_req is ignored (no restart).
- READY:
  - clear_req=1 at a posedge: state<=CLEAR, ready<=0, cnt<=0. Writes in that same cycle are still committed; reads in that cycle still return normal data.
  - Otherwise each enabled write port j writes file[wr_r[j]]<=wr_value[j].
  - Same-index multi-write: the highest-numbered enabled port wins.
- Read (READY), per port i, at each posedge:
  - rd_value[i] <= bypass value if any enabled write port targets rd_r[i]. The bypass value is the highest-numbered matching port's wr_value (write-first).
  - Otherwise rd_value[i] <= file[rd_r[i]].
  - Data is visible the cycle after the index is presented.
  - Multiple read ports may use the same index; all return identical data.
- ZERO_REG=1: writes to index 0 are dropped, reads of index 0 return 0, and no bypass applies to index 0.
- Out-of-range index (>= NUM_REGS, only when NUM_REGS is not a power of two): writes are dropped, reads return 0, bypass still matches only in-range writes.
- Reset mid-clear or mid-operation: returns immediately to CLEAR with cnt=0 and the sequence restarts from the beginning.
- No combinational path from inputs to rd_value or ready.

Test Plan:
- Reset release with NUM_REGS=16: ready=0 for 15 edges and goes 1 on edge 16. Read all indices after ready -> all 0. Writes attempted during clear (wr_r=3, wr_value=0xDEAD) -> r3 still reads 0.
- Write r5=0x12345678 on port0. Next cycle read rd_r[0]=5 and rd_r[1]=5 -> both ports return 0x12345678 one cycle later.
- Bypass: in the same cycle, write r7=0xAAAA0001 on port0 and read rd_r[0]=7 (old r7=0x11) -> rd_value[0]=0xAAAA0001 next cycle.
- Write collision: port0 r4=0x1 and port1 r4=0x2 in the same cycle, with a simultaneous read of r4 -> bypass value 0x2, and a later read of r4 gives 0x2.
- ZERO_REG=1: write r0=0xFFFFFFFF, then read r0 in the same cycle and the next cycle -> both 0.
- clear_req in READY after filling r1..r15 with nonzero data -> ready drops next edge and returns after 16 edges; all registers read 0. A clear_req pulse mid-clear does not extend the sequence. An rst_n pulse mid-clear restarts the 16-edge count.

Source files
------------

// File: rtl/core_reg_file_mp.sv
// Multi-port register file with registered, write-first reads and a
// counter-driven clear sequencer that zeroes the array after reset or on request.
module core_reg_file_mp #(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 16,
  parameter  int RD_PORTS = 2,
  parameter  int WR_PORTS = 2,
  parameter  int ZERO_REG = 0,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_req,
  input  logic [RD_PORTS*IDX_W-1:0]    rd_r,
  input  logic [WR_PORTS*IDX_W-1:0]    wr_r,
  input  logic [WR_PORTS-1:0]          wr_enable,
  input  logic [WR_PORTS*WIDTH-1:0]    wr_value,
  output logic [RD_PORTS*WIDTH-1:0]    rd_value,
  output logic                         ready
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]              r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic                    r_ready;
  logic [RD_PORTS*WIDTH-1:0] r_rd_value;
  logic [WIDTH-1:0]        r_file [NUM_REGS];

  logic [WR_PORTS-1:0]     w_wr_ok;
  logic                    w_hit  [NUM_REGS];
  logic [WIDTH-1:0]        w_data [NUM_REGS];
  logic [RD_PORTS*WIDTH-1:0] w_rd_next;

  // A write port is usable only if it targets an in-range, writable register.
  // NOTE: every always_comb output gets a default before the loops so no latch is inferred.
  always_comb begin
    w_wr_ok = '0;
    for (int j = 0; j < WR_PORTS; j++) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_r[j*IDX_W +: IDX_W] == IDX_W'(k) && !(ZERO_REG != 0 && k == 0))
          w_wr_ok[j] = wr_enable[j];
      end
    end
  end

  // Per-register write resolution; ascending port order lets the highest port win.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      w_hit[k]  = 1'b0;
      w_data[k] = '0;
      for (int j = 0; j < WR_PORTS; j++) begin
        if (w_wr_ok[j] && wr_r[j*IDX_W +: IDX_W] == IDX_W'(k)) begin
          w_hit[k]  = 1'b1;
          w_data[k] = wr_value[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read mux reuses the resolved write data as the write-first bypass.
  always_comb begin
    w_rd_next = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (rd_r[i*IDX_W +: IDX_W] == IDX_W'(k) && !(ZERO_REG != 0 && k == 0))
          w_rd_next[i*WIDTH +: WIDTH] = w_hit[k] ? w_data[k] : r_file[k];
      end
    end
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it, keeping it RAM-friendly.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_file
    always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
        if (r_cnt == IDX_W'(k))
          r_file[k] <= '0;
      end else if (w_hit[k]) begin
        r_file[k] <= w_data[k];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_rd_value <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rd_value <= '0;
          if (r_cnt == IDX_W'(NUM_REGS - 1)) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        default: begin
          r_rd_value <= w_rd_next;
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign rd_value = r_rd_value;
  assign ready    = r_ready;

endmodule
